// File: rtl/vga_hit_probe.sv
// vga_hit_probe: scores a click by counting duck-key pixels in a window around the cursor over the next full frame.
// Optional PROBE_SCORE_EN adds a saturating 8-bit hit score output.
module vga_hit_probe #(
    parameter int          H_ACTIVE = 1024,
    parameter int          V_ACTIVE = 768,
    parameter logic [11:0] KEY_RGB  = 12'hA52,
    parameter logic [11:0] KEY_MASK = 12'hFFF,
    parameter int          WIN      = 4,
    parameter int          MIN_HITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] vcount,
    input  logic [10:0] hcount,
    input  logic        vblnk,
    input  logic        hblnk,
    input  logic [11:0] rgb,
    input  logic        click,
    input  logic [10:0] xpos,
    input  logic [10:0] ypos,
    output logic        busy,
    output logic        hit,
    output logic        miss
`ifdef PROBE_SCORE_EN
    ,
    output logic [7:0]  score
`endif
);
    localparam logic [11:0] WIN_W = 12'(WIN);
    localparam logic [11:0] H_MAX = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_MAX = 12'(V_ACTIVE - 1);
    localparam logic [11:0] MIN_W = 12'(MIN_HITS);

    typedef enum logic [1:0] {IDLE, ARMED, SCAN, DECIDE} state_t;

    state_t      state_q, state_d;
    logic [11:0] count_q, count_d;
    logic [11:0] x_lo_q, x_lo_d, x_hi_q, x_hi_d;
    logic [11:0] y_lo_q, y_lo_d, y_hi_q, y_hi_d;
    logic        valid_q, valid_d, last_q, last_d;
    logic [11:0] xw, yw, hw, vw;
    logic        in_win, key_px, frame_start, last_px;

    assign xw          = {1'b0, xpos};
    assign yw          = {1'b0, ypos};
    assign hw          = {1'b0, hcount};
    assign vw          = {1'b0, vcount};
    assign in_win      = valid_q && hw >= x_lo_q && hw <= x_hi_q && vw >= y_lo_q && vw <= y_hi_q;
    assign key_px      = !hblnk && !vblnk && in_win && ((rgb & KEY_MASK) == (KEY_RGB & KEY_MASK));
    assign frame_start = vcount == 11'd0 && hcount == 11'd0;
    assign last_px     = vw == V_MAX && hw == H_MAX;
    assign busy        = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        x_lo_d  = x_lo_q;
        x_hi_d  = x_hi_q;
        y_lo_d  = y_lo_q;
        y_hi_d  = y_hi_q;
        valid_d = valid_q;
        last_d  = 1'b0;
        hit     = 1'b0;
        miss    = 1'b0;
        case (state_q)
            IDLE: if (click) begin
                x_lo_d  = (xw >= WIN_W) ? xw - WIN_W : 12'd0;
                x_hi_d  = (xw + WIN_W > H_MAX) ? H_MAX : xw + WIN_W;
                y_lo_d  = (yw >= WIN_W) ? yw - WIN_W : 12'd0;
                y_hi_d  = (yw + WIN_W > V_MAX) ? V_MAX : yw + WIN_W;
                // an off-screen cursor must never score, even where clamping would leave a sliver
                valid_d = xw <= H_MAX && yw <= V_MAX;
                state_d = ARMED;
            end
            ARMED: if (frame_start) begin
                count_d = key_px ? 12'd1 : 12'd0;
                state_d = SCAN;
            end
            SCAN: begin
                count_d = (key_px && count_q != 12'hFFF) ? count_q + 12'd1 : count_q;
                last_d  = last_px;
                state_d = last_q ? DECIDE : SCAN;
            end
            DECIDE: begin
                hit     = count_q >= MIN_W;
                miss    = !(count_q >= MIN_W);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            x_lo_q  <= '0;
            x_hi_q  <= '0;
            y_lo_q  <= '0;
            y_hi_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            x_lo_q  <= x_lo_d;
            x_hi_q  <= x_hi_d;
            y_lo_q  <= y_lo_d;
            y_hi_q  <= y_hi_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

`ifdef PROBE_SCORE_EN
    logic [7:0] score_q, score_d;

    assign score_d = (hit && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
    assign score   = score_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) score_q <= '0;
        else      score_q <= score_d;
    end
`endif
endmodule

// File: tb/tb_vga_hit_probe.sv
// tb_vga_hit_probe: table-driven check of vga_hit_probe on a shrunken 16x12 raster (18x13 with blanking).
module tb_vga_hit_probe;
    localparam int H = 16, V = 12, HT = 18, VT = 13, FRAME = HT * VT;

    logic        clk = 1'b0, rst = 1'b0, click = 1'b0;
    logic [10:0] vcount, hcount, xpos = '0, ypos = '0;
    logic        vblnk, hblnk, busy, hit, miss;
    logic [11:0] rgb;
`ifdef PROBE_SCORE_EN
    logic [7:0]  score;
`endif
    int total = 0, bad = 0, frame_no = 0;
    int px_lo = 99, px_hi = 0, py_lo = 99, py_hi = 0;

    vga_hit_probe #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk(clk), .rst(rst), .vcount(vcount), .hcount(hcount), .vblnk(vblnk), .hblnk(hblnk),
        .rgb(rgb), .click(click), .xpos(xpos), .ypos(ypos), .busy(busy), .hit(hit), .miss(miss)
`ifdef PROBE_SCORE_EN
        , .score(score)
`endif
    );

    always #5 clk = ~clk;

    task automatic paint_pix();
        hblnk = int'(hcount) >= H;
        vblnk = int'(vcount) >= V;
        rgb = (int'(hcount) >= px_lo && int'(hcount) <= px_hi && int'(vcount) >= py_lo && int'(vcount) <= py_hi)
              ? 12'hA52 : 12'hA53;
    endtask

    initial begin
        hcount = '0;
        vcount = '0;
        paint_pix();
        forever begin
            @(posedge clk);
            #1;
            if (int'(hcount) == HT - 1) begin
                hcount = '0;
                if (int'(vcount) == VT - 1) begin
                    vcount = '0;
                    frame_no++;
                end else vcount = vcount + 11'd1;
            end else hcount = hcount + 11'd1;
            paint_pix();
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_at(input int v);
        bit ok = 0;
        for (int i = 0; i < 2 * FRAME && !ok; i++) begin
            @(negedge clk);
            ok = int'(vcount) == v && hcount == 11'd0;
        end
        if (!ok) chk("wait_line_timeout", 0, 1);
    endtask

    task automatic wait_pulse(output bit got);
        got = 0;
        for (int i = 0; i < 3 * FRAME && !got; i++) begin
            @(negedge clk);
            got = hit || miss;
        end
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (hit || miss) n++;
        end
    endtask

    task automatic do_click(input int x, input int y);
        click = 1'b1;
        xpos = 11'(x);
        ypos = 11'(y);
        @(negedge clk);
        click = 1'b0;
    endtask

    task automatic set_paint(input int xl, input int xh, input int yl, input int yh);
        px_lo = xl; px_hi = xh; py_lo = yl; py_hi = yh;
    endtask

    typedef struct {
        string name;
        int    cx, cy, xl, xh, yl, yh;
        bit    exp_hit;
    } vec_t;

    task automatic run_vec(input vec_t t);
        bit got;
        int f;
        set_paint(t.xl, t.xh, t.yl, t.yh);
        wait_at(5);
        f = frame_no;
        do_click(t.cx, t.cy);
        wait_pulse(got);
        chk({t.name, "_pulse_seen"}, int'(got), 1);
        if (got) begin
            chk({t.name, "_hit"}, int'(hit), int'(t.exp_hit));
            chk({t.name, "_miss"}, int'(miss), int'(!t.exp_hit));
            chk({t.name, "_busy_at_pulse"}, int'(busy), 1);
            chk({t.name, "_frame"}, frame_no, f + 1);
            chk({t.name, "_hcount_at_pulse"}, int'(hcount), H + 1);
            chk({t.name, "_vcount_at_pulse"}, int'(vcount), V - 1);
            @(negedge clk);
            chk({t.name, "_pulse_width"}, int'(hit || miss), 0);
            chk({t.name, "_idle_after"}, int'(busy), 0);
        end
    endtask

    vec_t vecs[13];
    vec_t v_hit;

    initial begin
        bit got;
        int n, f;
        vecs[0]  = '{"block5x5",    8,  6,  6, 10,  4,  8, 1'b1};
        vecs[1]  = '{"no_key",      8,  6, 99,  0, 99,  0, 1'b0};
        vecs[2]  = '{"clamp_tl",    1,  1,  0,  5,  0,  5, 1'b1};
        vecs[3]  = '{"x_far_off",  20,  6,  0, 99,  0, 99, 1'b0};
        vecs[4]  = '{"x_just_off", 17,  6,  0, 99,  0, 99, 1'b0};
        vecs[5]  = '{"y_at_v",      8, 12,  0, 99,  0, 99, 1'b0};
        vecs[6]  = '{"two_edge",    8,  6, 11, 13,  6,  6, 1'b0};
        vecs[7]  = '{"three_edge",  8,  6, 10, 13,  6,  6, 1'b1};
        vecs[8]  = '{"clamp_br",   15, 11,  0, 99,  0, 99, 1'b1};
        vecs[9]  = '{"two_vert",    8,  6,  8,  8,  1,  3, 1'b0};
        vecs[10] = '{"three_vert",  8,  6,  8,  8,  1,  4, 1'b1};
        vecs[11] = '{"origin_px",   0,  0,  0,  0,  0,  2, 1'b1};
        vecs[12] = '{"lo_eq_zero",  4,  4,  0,  0,  4,  6, 1'b1};
        v_hit = vecs[0];

        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_hit", int'(hit), 0);
        chk("reset_miss", int'(miss), 0);
`ifdef PROBE_SCORE_EN
        chk("reset_score", int'(score), 0);
`endif
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset while scanning: abort with no pulse, then a clean run
        set_paint(0, 99, 0, 99);
        wait_at(5);
        do_click(8, 6);
        wait_at(5);
        chk("rst_mid_in_scan", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_pulse", int'(hit || miss), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        count_pulses(2 * FRAME, n);
        chk("rst_mid_no_pulse", n, 0);
        run_vec(v_hit);

        // second click during SCAN is ignored
        set_paint(0, 99, 0, 99);
        wait_at(5);
        f = frame_no;
        do_click(20, 6);
        wait_at(5);
        do_click(8, 6);
        wait_pulse(got);
        chk("scan_click_pulse", int'(got), 1);
        chk("scan_click_miss", int'(miss), 1);
        chk("scan_click_frame", frame_no, f + 1);
        count_pulses(2 * FRAME, n);
        chk("scan_click_one_pulse", n, 0);

        // click presented in the DECIDE cycle is ignored
        wait_at(5);
        do_click(8, 6);
        wait_pulse(got);
        chk("decide_click_pulse", int'(got), 1);
        do_click(8, 6);
        chk("decide_click_idle", int'(busy), 0);
        count_pulses(2 * FRAME, n);
        chk("decide_click_no_pulse", n, 0);

`ifdef PROBE_SCORE_EN
        rst = 1'b0;
        #3 rst = 1'b1;
        set_paint(6, 10, 4, 8);
        wait_at(5);
        do_click(8, 6);
        for (int i = 0; i < 300; i++) begin
            wait_pulse(got);
            if (!got || !hit) begin
                chk("score_hit_pulse", int'(got && hit), 1);
                break;
            end
            @(negedge clk);
            if (i == 0) chk("score_first", int'(score), 1);
            if (i == 254) chk("score_reach_max", int'(score), 255);
            do_click(8, 6);
        end
        chk("score_saturated", int'(score), 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
